load_unit_seq: RTL and testbench

//  Sequential load unit: successor to the combinational load decoder. Accepts a load
//  (instruction_code[31:7] + rs1 value), decodes rd/rs1/imm/funct3, computes the address,
//  and issues word-aligned bus reads (valid/ready). It aligns and sign/zero-extends the

---
 rtl/load_unit_seq.sv | 181 ++++++++++++++++++
 tb/tb_load_unit_seq.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit_seq.sv
// Sequential load unit: decodes a load, issues word-aligned bus reads, aligns/extends the result.
// Optional feature macro: MISALIGNED_SPLIT_EN (word-crossing loads become two bus reads).
module load_unit_seq #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [24:0]       instruction_code,
  input  logic [XLEN-1:0]   rs1_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              exc_valid,
  output logic [1:0]        exc_cause,
  output logic              busy
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int SUM_W = (XLEN > ADDR_W) ? XLEN : ADDR_W;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE, S_CHK, S_REQ0, S_RSP0, S_REQ1, S_RSP1, S_WB, S_EXC
  } state_t;

  state_t            state_reg, state_next;
  logic [4:0]        rd_reg;
  logic [2:0]        funct3_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [XLEN-1:0]   rsp0_reg, rsp1_reg;
  logic [1:0]        cause_reg;
  logic [31:0]       tmo_cnt_reg;

  logic [11:0]       in_imm;
  logic [SUM_W-1:0]  in_sum;
  logic              legal;
  logic [3:0]        size;
  logic [OFF_W-1:0]  off;
  logic              need_second;
  logic              tmo_hit;
  logic [ADDR_W-1:0] word_addr;
  logic [XLEN-1:0]   low;
  logic [XLEN-1:0]   result;
  logic              unused_bits;

  // The rs1 index is decoded for completeness; its value arrives on rs1_data.
  assign unused_bits = ^{instruction_code[12:8], in_sum};

  assign in_imm = instruction_code[24:13];
  assign in_sum = SUM_W'(rs1_data) + SUM_W'(signed'(in_imm));

  always_comb begin
    legal = 1'b0;
    size  = 4'd1;
    case (funct3_reg)
      F_LB, F_LBU: begin legal = 1'b1; size = 4'd1; end
      F_LH, F_LHU: begin legal = 1'b1; size = 4'd2; end
      F_LW:        begin legal = 1'b1; size = 4'd4; end
      default:     begin legal = 1'b0; size = 4'd1; end
    endcase
  end

  assign off = addr_reg[OFF_W-1:0];

`ifdef MISALIGNED_SPLIT_EN
  assign need_second = (int'(off) + int'(size)) > NB;
`else
  logic misaligned;
  assign misaligned  = ((size == 4'd2) && off[0]) || ((size == 4'd4) && (off[1:0] != 2'b00));
  assign need_second = 1'b0;
`endif

  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt_reg == 32'(TIMEOUT_CYCLES - 1));
  assign word_addr = {addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Two-word window shifted down so the addressed byte lands at bit 0.
  assign low = XLEN'({rsp1_reg, rsp0_reg} >> {off, 3'b000});

  always_comb begin
    result = '0;
    case (funct3_reg)
      F_LB:    result = XLEN'(signed'(low[7:0]));
      F_LBU:   result = XLEN'(low[7:0]);
      F_LH:    result = XLEN'(signed'(low[15:0]));
      F_LHU:   result = XLEN'(low[15:0]);
      F_LW:    result = XLEN'(signed'(low[31:0]));
      default: result = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (in_valid) state_next = S_CHK;
      S_CHK: begin
        if (!legal) state_next = S_EXC;
`ifndef MISALIGNED_SPLIT_EN
        else if (misaligned) state_next = S_EXC;
`endif
        else state_next = S_REQ0;
      end
      S_REQ0: if (mem_req_ready) state_next = S_RSP0;
      S_RSP0: begin
        if (mem_rsp_valid) state_next = need_second ? S_REQ1 : S_WB;
        else if (tmo_hit)  state_next = S_EXC;
      end
      S_REQ1: if (mem_req_ready) state_next = S_RSP1;
      S_RSP1: begin
        if (mem_rsp_valid) state_next = S_WB;
        else if (tmo_hit)  state_next = S_EXC;
      end
      S_WB:    if (wb_ready) state_next = S_IDLE;
      S_EXC:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready      = (state_reg == S_IDLE);
    busy          = (state_reg != S_IDLE);
    mem_req_valid = (state_reg == S_REQ0) || (state_reg == S_REQ1);
    mem_req_addr  = '0;
    if (state_reg == S_REQ0) mem_req_addr = word_addr;
    if (state_reg == S_REQ1) mem_req_addr = word_addr + ADDR_W'(NB);
    wb_valid      = (state_reg == S_WB);
    wb_rd         = (state_reg == S_WB) ? rd_reg : 5'd0;
    wb_data       = (state_reg == S_WB) ? result : '0;
    exc_valid     = (state_reg == S_EXC);
    exc_cause     = (state_reg == S_EXC) ? cause_reg : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      rd_reg      <= '0;
      funct3_reg  <= '0;
      addr_reg    <= '0;
      rsp0_reg    <= '0;
      rsp1_reg    <= '0;
      cause_reg   <= '0;
      tmo_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == S_IDLE) && in_valid) begin
        rd_reg     <= instruction_code[4:0];
        funct3_reg <= instruction_code[7:5];
        addr_reg   <= in_sum[ADDR_W-1:0];
        rsp0_reg   <= '0;
        rsp1_reg   <= '0;
      end
      if ((state_reg == S_RSP0) && mem_rsp_valid) rsp0_reg <= mem_rsp_data;
      if ((state_reg == S_RSP1) && mem_rsp_valid) rsp1_reg <= mem_rsp_data;
      // Held at zero while requesting, so every RSPx phase starts counting fresh.
      if ((state_reg == S_REQ0) || (state_reg == S_REQ1))
        tmo_cnt_reg <= '0;
      else if (((state_reg == S_RSP0) || (state_reg == S_RSP1)) && !mem_rsp_valid)
        tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
      if (state_reg == S_CHK)
        cause_reg <= legal ? 2'b01 : 2'b11;
      else if ((state_reg == S_RSP0) || (state_reg == S_RSP1))
        cause_reg <= 2'b10;
    end
  end

endmodule

// File: tb/tb_load_unit_seq.sv
// Self-checking bench for load_unit_seq: directed scenarios plus random loads vs a byte-level model.
module tb_load_unit_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [24:0] instruction_code = '0;
  logic [31:0] rs1_data = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] rsp_q[$];
  logic [31:0] obs_req_addr[$];
  bit          obs_wb, obs_exc, stable_ok;
  logic [4:0]  obs_wb_rd;
  logic [31:0] obs_wb_data;
  logic [1:0]  obs_cause;
  int          t_xfer, t_req1st, t_reqx, t_wb, t_exc;

  load_unit_seq #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction_code(instruction_code), .rs1_data(rs1_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] enc(input logic [11:0] imm, input logic [4:0] r1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {imm, r1, f3, rd};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_F00F;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word({a[31:2], 2'b00});
    return 8'(w >> (8 * a[1:0]));
  endfunction

  // Byte-addressed view of memory: gather size bytes little-endian, then extend.
  function automatic void model(input logic [24:0] ic, input logic [31:0] rs1,
                                output bit e_exc, output logic [1:0] e_cause,
                                output logic [31:0] e_data, output int e_nreq,
                                output logic [31:0] e_a0, output logic [31:0] e_a1);
    logic [2:0]  f3;
    logic [31:0] addr;
    int          size;
    bit          split;
`ifdef MISALIGNED_SPLIT_EN
    split = 1'b1;
`else
    split = 1'b0;
`endif
    f3     = ic[7:5];
    addr   = rs1 + {{20{ic[24]}}, ic[24:13]};
    size   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e_exc  = 1'b0; e_cause = 2'b00; e_data = '0;
    e_a0   = {addr[31:2], 2'b00};
    e_a1   = e_a0 + 32'd4;
    e_nreq = ((int'(addr[1:0]) + size) > 4) ? 2 : 1;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
      e_exc = 1'b1; e_cause = 2'b11; e_nreq = 0;
    end else if (!split && (addr % size) != 0) begin
      e_exc = 1'b1; e_cause = 2'b01; e_nreq = 0;
    end else begin
      for (int i = 0; i < size; i++) e_data |= 32'(byte_at(addr + i)) << (8 * i);
      if (!f3[2] && size < 4 && e_data[8*size-1]) e_data |= 32'hFFFF_FFFF << (8 * size);
    end
  endfunction

  // Drives one load through every handshake, acting as bus and writeback sink.
  task automatic run_load(input logic [24:0] ic, input logic [31:0] rs1, input int req_wait,
                          input int rsp_wait, input int wb_wait, input bit give_rsp);
    int          req_ctr, wb_ctr, cyc;
    int          rsp_due[$];
    logic [31:0] pend_addr[$];
    bit          in_done, fin, req_hold, wb_hold;
    logic [31:0] held_addr, held_wbd;
    logic [4:0]  held_rd;
    obs_req_addr.delete();
    obs_wb = 0; obs_exc = 0; obs_cause = 0; obs_wb_rd = 0; obs_wb_data = 0; stable_ok = 1;
    t_xfer = -1; t_req1st = -1; t_reqx = -1; t_wb = -1; t_exc = -1;
    req_ctr = 0; wb_ctr = 0; in_done = 0; fin = 0; req_hold = 0; wb_hold = 0;
    held_addr = '0; held_wbd = '0; held_rd = '0;
    instruction_code = ic; rs1_data = rs1; in_valid = 1'b1;
    for (cyc = 0; cyc < 300 && !fin; cyc++) begin
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; wb_ready = 1'b0;
      if (mem_req_valid) begin
        if (t_req1st < 0) t_req1st = cyc;
        if (req_hold && mem_req_addr !== held_addr) stable_ok = 0;
        mem_req_ready = (req_ctr >= req_wait);
        req_ctr++;
      end
      if (rsp_due.size() > 0 && rsp_due[0] == cyc) begin
        void'(rsp_due.pop_front());
        mem_rsp_valid = 1'b1;
        if (rsp_q.size() > 0) mem_rsp_data = rsp_q.pop_front();
        else mem_rsp_data = mem_word(pend_addr[0]);
        void'(pend_addr.pop_front());
      end
      if (wb_valid) begin
        if (t_wb < 0) t_wb = cyc;
        if (wb_hold && (wb_rd !== held_rd || wb_data !== held_wbd)) stable_ok = 0;
        wb_ready = (wb_ctr >= wb_wait);
        wb_ctr++;
        if (wb_ready) begin obs_wb = 1; obs_wb_rd = wb_rd; obs_wb_data = wb_data; fin = 1; end
        wb_hold = 1; held_rd = wb_rd; held_wbd = wb_data;
      end
      if (exc_valid) begin obs_exc = 1; obs_cause = exc_cause; t_exc = cyc; fin = 1; end
      if (mem_req_valid && mem_req_ready) begin
        obs_req_addr.push_back(mem_req_addr);
        t_reqx = cyc; req_ctr = 0; req_hold = 0;
        if (give_rsp) begin
          pend_addr.push_back(mem_req_addr);
          rsp_due.push_back(cyc + 1 + rsp_wait);
        end
      end else if (mem_req_valid) begin
        req_hold = 1; held_addr = mem_req_addr;
      end
      if (in_valid && in_ready && !in_done) begin t_xfer = cyc; in_done = 1; end
      @(negedge clk);
      if (in_done) in_valid = 1'b0;
    end
    in_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; wb_ready = 1'b0;
    total++;
    if (!fin) begin
      bad++;
      $display("FAIL load_timeout: no wb or exc within 300 cycles (required one of them)");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, mem_req_valid, wb_valid, exc_valid, busy} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b required 10000", {in_ready, mem_req_valid, wb_valid, exc_valid, busy});
    end
    total++;
    if ({mem_req_addr, wb_rd, wb_data, exc_cause} !== '0) begin
      bad++;
      $display("FAIL reset_data: addr=%h rd=%0d data=%h cause=%b required all 0",
               mem_req_addr, wb_rd, wb_data, exc_cause);
    end
  endtask

  task automatic test_lb();
    run_load(enc(12'hFFC, 5'd1, 3'b000, 5'd5), 32'h1000_0007, 0, 0, 0, 1'b0 == 1'b1 ? 1'b0 : 1'b1);
  endtask

  task automatic test_lb_vector();
    rsp_q.delete();
    rsp_q.push_back(32'h80AA_BBCC);
    run_load(enc(12'hFFC, 5'd1, 3'b000, 5'd5), 32'h1000_0007, 0, 0, 0, 1'b1);
    total++;
    if (obs_req_addr.size() != 1 || obs_req_addr[0] !== 32'h1000_0000) begin
      bad++;
      $display("FAIL lb_addr: got %0d reqs first=%h required 1 req 10000000",
               obs_req_addr.size(), obs_req_addr.size() > 0 ? obs_req_addr[0] : 32'h0);
    end
    total++;
    if (!obs_wb || obs_wb_rd !== 5'd5 || obs_wb_data !== 32'hFFFF_FF80) begin
      bad++;
      $display("FAIL lb_wb: got wb=%0d rd=%0d data=%h required rd=5 data=ffffff80",
               obs_wb, obs_wb_rd, obs_wb_data);
    end
    total++;
    if (t_req1st != t_xfer + 2 || t_wb != t_xfer + 4) begin
      bad++;
      $display("FAIL lb_latency: req at +%0d wb at +%0d required +2 and +4",
               t_req1st - t_xfer, t_wb - t_xfer);
    end
  endtask

  task automatic test_misaligned();
    rsp_q.delete();
    rsp_q.push_back(32'h1122_3344);
    rsp_q.push_back(32'h5566_7788);
    run_load(enc(12'h000, 5'd2, 3'b101, 5'd9), 32'h0000_2003, 0, 1, 0, 1'b1);
    rsp_q.delete();
`ifdef MISALIGNED_SPLIT_EN
    total++;
    if (obs_req_addr.size() != 2 || obs_req_addr[0] !== 32'h2000 || obs_req_addr[1] !== 32'h2004) begin
      bad++;
      $display("FAIL split_addrs: got %0d reqs required 2000 then 2004", obs_req_addr.size());
    end
    total++;
    if (!obs_wb || obs_wb_data !== 32'h0000_8811) begin
      bad++;
      $display("FAIL split_data: got wb=%0d data=%h required 00008811", obs_wb, obs_wb_data);
    end
`else
    total++;
    if (!obs_exc || obs_cause !== 2'b01) begin
      bad++;
      $display("FAIL misal_exc: got exc=%0d cause=%b required exc=1 cause=01", obs_exc, obs_cause);
    end
    total++;
    if (t_req1st != -1 || obs_wb) begin
      bad++;
      $display("FAIL misal_nobus: got req_seen=%0d wb=%0d required no request and no wb",
               t_req1st != -1, obs_wb);
    end
`endif
  endtask

  task automatic test_stall();
    rsp_q.delete();
    rsp_q.push_back(32'hDEAD_BEEF);
    run_load(enc(12'h000, 5'd3, 3'b010, 5'd12), 32'h0000_0100, 5, 0, 0, 1'b1);
    total++;
    if (!stable_ok || obs_req_addr.size() != 1 || obs_req_addr[0] !== 32'h100) begin
      bad++;
      $display("FAIL stall_addr: stable=%0d reqs=%0d required stable addr 00000100 once",
               stable_ok, obs_req_addr.size());
    end
    total++;
    if (!obs_wb || obs_wb_data !== 32'hDEAD_BEEF || obs_wb_rd !== 5'd12) begin
      bad++;
      $display("FAIL stall_data: got data=%h rd=%0d required deadbeef rd=12", obs_wb_data, obs_wb_rd);
    end
  endtask

  task automatic test_illegal();
    run_load(enc(12'h010, 5'd4, 3'b011, 5'd7), 32'h0000_0040, 0, 0, 0, 1'b1);
    total++;
    if (!obs_exc || obs_cause !== 2'b11 || t_exc != t_xfer + 2) begin
      bad++;
      $display("FAIL illegal_exc: exc=%0d cause=%b at +%0d required cause=11 at +2",
               obs_exc, obs_cause, t_exc - t_xfer);
    end
    total++;
    if (t_req1st != -1) begin
      bad++;
      $display("FAIL illegal_nobus: request seen at +%0d required none", t_req1st - t_xfer);
    end
    total++;
    if (exc_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL exc_pulse: after exc exc_valid=%b in_ready=%b required 0 and 1", exc_valid, in_ready);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    run_load(enc(12'h000, 5'd1, 3'b010, 5'd3), 32'h0000_0200, 0, 0, 0, 1'b0);
    total++;
    if (!obs_exc || obs_cause !== 2'b10 || t_exc != t_reqx + 9) begin
      bad++;
      $display("FAIL timeout_exc: exc=%0d cause=%b at req+%0d required cause=10 at req+9",
               obs_exc, obs_cause, t_exc - t_reqx);
    end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0BAD_0BAD;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    total++;
    if (busy !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL late_rsp: busy=%b wb_valid=%b in_ready=%b required 0 0 1", busy, wb_valid, in_ready);
    end
    d = mem_word(32'h0000_0300);
    run_load(enc(12'h000, 5'd1, 3'b010, 5'd4), 32'h0000_0300, 0, 2, 0, 1'b1);
    total++;
    if (!obs_wb || obs_wb_data !== d) begin
      bad++;
      $display("FAIL after_timeout: got data=%h required %h", obs_wb_data, d);
    end
  endtask

  task automatic test_wb_stall_reset();
    int n;
    logic [31:0] d;
    d = mem_word(32'h0000_0400);
    run_load(enc(12'h002, 5'd6, 3'b101, 5'd21), 32'h0000_03FE, 0, 0, 3, 1'b1);
    total++;
    if (!stable_ok || !obs_wb || obs_wb_rd !== 5'd21 || obs_wb_data !== {16'h0, d[15:0]}) begin
      bad++;
      $display("FAIL wb_hold: stable=%0d rd=%0d data=%h required stable rd=21 data=%h",
               stable_ok, obs_wb_rd, obs_wb_data, {16'h0, d[15:0]});
    end
    instruction_code = enc(12'h000, 5'd1, 3'b010, 5'd8); rs1_data = 32'h0000_0040; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!mem_req_valid && n < 20) begin @(negedge clk); n++; end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    total++;
    if (busy !== 1'b1 || mem_req_valid !== 1'b0 || wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL in_rsp0: busy=%b req=%b wb=%b required 1 0 0", busy, mem_req_valid, wb_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({in_ready, mem_req_valid, wb_valid, exc_valid, busy} !== 5'b10000 ||
        {mem_req_addr, wb_rd, wb_data, exc_cause} !== '0) begin
      bad++;
      $display("FAIL mid_reset: ctrl=%b addr=%h rd=%0d data=%h required 10000 and zeros",
               {in_ready, mem_req_valid, wb_valid, exc_valid, busy}, mem_req_addr, wb_rd, wb_data);
    end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    total++;
    if (wb_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rsp_after_reset: wb_valid=%b busy=%b required 0 0", wb_valid, busy);
    end
  endtask

  task automatic test_random();
    bit          e_exc;
    logic [1:0]  e_cause;
    logic [31:0] e_data, e_a0, e_a1, rs1;
    int          e_nreq;
    logic [24:0] ic;
    for (int n = 0; n < 40; n++) begin
      ic  = enc(12'($urandom), 5'($urandom), 3'($urandom_range(0, 7)), 5'($urandom));
      rs1 = $urandom;
      model(ic, rs1, e_exc, e_cause, e_data, e_nreq, e_a0, e_a1);
      run_load(ic, rs1, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2), 1'b1);
      if (e_exc) begin
        total++;
        if (!obs_exc || obs_cause !== e_cause || obs_req_addr.size() != 0) begin
          bad++;
          $display("FAIL rnd_exc[%0d]: exc=%0d cause=%b reqs=%0d required cause=%b no reqs",
                   n, obs_exc, obs_cause, obs_req_addr.size(), e_cause);
        end
      end else begin
        total++;
        if (!obs_wb || obs_wb_data !== e_data || obs_wb_rd !== ic[4:0]) begin
          bad++;
          $display("FAIL rnd_wb[%0d]: rd=%0d data=%h required rd=%0d data=%h",
                   n, obs_wb_rd, obs_wb_data, ic[4:0], e_data);
        end
        total++;
        if (obs_req_addr.size() != e_nreq || obs_req_addr[0] !== e_a0 ||
            (e_nreq == 2 && obs_req_addr[1] !== e_a1) || !stable_ok) begin
          bad++;
          $display("FAIL rnd_req[%0d]: reqs=%0d stable=%0d required %0d reqs at %h/%h",
                   n, obs_req_addr.size(), stable_ok, e_nreq, e_a0, e_a1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lb_vector();
    test_misaligned();
    test_stall();
    test_illegal();
    test_timeout();
    test_wb_stall_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
